// File: rtl/store_buffer.sv
// In-order write buffer between store alignment and the single-port data memory.
// Drains one store per cycle whenever no load owns the port; flags RAW hazards for loads.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned W_SIZE = 32,
  parameter int unsigned A_SIZE = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [A_SIZE-1:0]          st_addr,
  input  logic [W_SIZE-1:0]          st_data,
  input  logic [3:0]                 st_mask,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [A_SIZE-1:0]          ld_addr,
  output logic                       ld_hazard,
  output logic [A_SIZE-1:0]          mem_addr,
  output logic [W_SIZE-1:0]          mem_din,
  output logic [3:0]                 mem_we,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [A_SIZE-1:0] addr;
    logic [W_SIZE-1:0] data;
    logic [3:0]        mask;
  } entry_t;

  entry_t            entry_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  logic enq;
  logic deq;
  logic hit;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = (count_q < CW'(DEPTH));
  assign enq      = st_valid & st_ready & (|st_mask);
  assign deq      = !empty & !ld_valid;

  assign mem_addr = entry_q[head_q].addr;
  assign mem_din  = entry_q[head_q].data;
  assign mem_we   = deq ? entry_q[head_q].mask : 4'b0000;

  // Only entries resident at the start of the cycle take part in the compare.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (entry_q[i].addr == ld_addr)) hit = 1'b1;
    end
  end

  assign ld_hazard = ld_valid & hit;

  // Payload storage needs no reset; occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (enq) entry_q[tail_q] <= '{addr: st_addr, data: st_data, mask: st_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (enq) begin
        tail_q         <= tail_q + PW'(1);
        vld_q[tail_q]  <= 1'b1;
      end
      if (deq) begin
        head_q         <= head_q + PW'(1);
        vld_q[head_q]  <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed test-plan steps plus a random phase,
// every cycle checked against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned W_SIZE = 32;
  localparam int unsigned A_SIZE = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic [A_SIZE-1:0] st_addr;
  logic [W_SIZE-1:0] st_data;
  logic [3:0]        st_mask;
  logic              st_ready;
  logic              ld_valid;
  logic [A_SIZE-1:0] ld_addr;
  logic              ld_hazard;
  logic [A_SIZE-1:0] mem_addr;
  logic [W_SIZE-1:0] mem_din;
  logic [3:0]        mem_we;
  logic [2:0]        count;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .W_SIZE(W_SIZE), .A_SIZE(A_SIZE)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [A_SIZE-1:0] a;
    logic [W_SIZE-1:0] d;
    logic [3:0]        m;
  } ent_t;

  ent_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [A_SIZE-1:0] sa, input logic [W_SIZE-1:0] sd,
                       input logic [3:0] sm, input logic lv, input logic [A_SIZE-1:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; st_mask = sm;
    ld_valid = lv; ld_addr = la;
  endtask

  task automatic idle(input logic lv);
    drive(1'b0, '0, '0, 4'b0000, lv, '0);
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic settle();
    logic       haz;
    logic [3:0] we;
    @(negedge clk);
    haz = 1'b0;
    foreach (q[i]) if (q[i].a == ld_addr) haz = 1'b1;
    haz = haz & ld_valid;
    we  = (q.size() > 0 && !ld_valid) ? q[0].m : 4'b0000;
    chk("count",     64'(count),    64'(q.size()));
    chk("empty",     64'(empty),    64'(q.size() == 0));
    chk("st_ready",  64'(st_ready), 64'(q.size() < DEPTH));
    chk("ld_hazard", 64'(ld_hazard), 64'(haz));
    chk("mem_we",    64'(mem_we),   64'(we));
    if (we != 4'b0000) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
      chk("mem_din",  64'(mem_din),  64'(q[0].d));
    end
  endtask

  // Advance one clock edge and apply the buffer rules to the model.
  task automatic edge_step();
    ent_t e;
    bit   do_deq;
    bit   do_enq;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      do_deq = (q.size() > 0) && !ld_valid;
      do_enq = st_valid && (q.size() < DEPTH) && (st_mask != 4'b0000);
      e.a = st_addr; e.d = st_data; e.m = st_mask;
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(e);
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    edge_step();
    q.delete();
    settle();
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_ready", 64'(st_ready), 64'd1);
    edge_step();
    rst = 1'b0;

    // Single store
    drive(1'b1, 14'h0010, 32'hDEADBEEF, 4'b1111, 1'b0, '0);
    cyc();
    idle(1'b0);
    settle();
    chk("single_we",   64'(mem_we),   64'hF);
    chk("single_addr", 64'(mem_addr), 64'h0010);
    chk("single_din",  64'(mem_din),  64'hDEADBEEF);
    edge_step();
    settle();
    chk("single_empty", 64'(empty), 64'd1);
    edge_step();

    // Fill with load holding the port, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, A_SIZE'(i), W_SIZE'(32'hA0 + i), 4'b1111, 1'b1, 14'h3FFF);
      cyc();
    end
    drive(1'b1, 14'h0005, 32'hA5, 4'b1111, 1'b1, 14'h3FFF);
    settle();
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    edge_step();
    idle(1'b0);
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("drain_addr", 64'(mem_addr), 64'(i));
      chk("drain_din",  64'(mem_din),  64'(32'hA0 + i));
      chk("drain_we",   64'(mem_we),   64'hF);
      edge_step();
    end
    settle();
    chk("drain_empty", 64'(empty), 64'd1);
    edge_step();

    // Hazard detection
    drive(1'b1, 14'h0022, 32'h2222_0000, 4'b0011, 1'b1, 14'h0022);
    settle();
    chk("haz_same_cycle", 64'(ld_hazard), 64'd0);
    edge_step();
    idle(1'b1); ld_addr = 14'h0022;
    settle();
    chk("haz_match", 64'(ld_hazard), 64'd1);
    edge_step();
    ld_addr = 14'h0023;
    settle();
    chk("haz_nomatch", 64'(ld_hazard), 64'd0);
    edge_step();
    idle(1'b0);
    cyc();
    idle(1'b1); ld_addr = 14'h0022;
    settle();
    chk("haz_retry", 64'(ld_hazard), 64'd0);
    edge_step();

    // Zero mask dropped
    drive(1'b1, 14'h0040, 32'h4040, 4'b0000, 1'b0, '0);
    cyc();
    idle(1'b0);
    settle();
    chk("zmask_count", 64'(count), 64'd0);
    chk("zmask_we",    64'(mem_we), 64'd0);
    edge_step();

    // Simultaneous enqueue and drain with count = 2
    drive(1'b1, 14'h0030, 32'h30, 4'b0001, 1'b1, 14'h3FFF); cyc();
    drive(1'b1, 14'h0031, 32'h31, 4'b0010, 1'b1, 14'h3FFF); cyc();
    drive(1'b1, 14'h0032, 32'h32, 4'b0100, 1'b0, '0);
    settle();
    chk("sim_head", 64'(mem_addr), 64'h0030);
    edge_step();
    idle(1'b0);
    settle();
    chk("sim_count", 64'(count), 64'd2);
    chk("sim_next",  64'(mem_addr), 64'h0031);
    edge_step();
    for (int i = 0; i < 3; i++) cyc();

    // Pointer wrap with interleaved drains
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, A_SIZE'(16'h0100 + i), W_SIZE'(32'hB0 + i), 4'b1111, (i % 2) == 0, 14'h3FFF);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin idle(1'b0); cyc(); end

    // Reset discards pending stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, A_SIZE'(16'h0200 + i), W_SIZE'(32'hC0 + i), 4'b1111, 1'b1, 14'h3FFF);
      cyc();
    end
    idle(1'b0);
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_count", 64'(count),  64'd0);
      edge_step();
    end

    // Random phase
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 60, A_SIZE'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom()),
            $urandom_range(0, 99) < 40, A_SIZE'($urandom_range(0, 7)));
      cyc();
    end
    rst = 1'b0;
    idle(1'b0);
    for (int i = 0; i < 6; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the store-alignment stage and the data-memory write port. It queues up to DEPTH pending stores (word address, write data, byte mask) and drains them in order into the single-port data memory whenever no load owns the port. It also flags read-after-write hazards for loads that target a word still held in the buffer. Stores are never merged, reordered or forwarded.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- W_SIZE, 32, data width
- A_SIZE, 14, word-address width

Ports:
- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, synchronous, active-high reset
- st_valid, in, 1, store request this cycle
- st_addr, in, A_SIZE, word address of the store
- st_data, in, W_SIZE, write data, already lane-aligned upstream
- st_mask, in, 4, byte-write mask
- st_ready, out, 1, buffer can accept a store this cycle
- ld_valid, in, 1, a load uses the memory port this cycle
- ld_addr, in, A_SIZE, word address of that load
- ld_hazard, out, 1, the load matches a buffered store; the core must stall
- mem_addr, out, A_SIZE, memory write address
- mem_din, out, W_SIZE, memory write data
- mem_we, out, 4, memory byte write enables; 0 means no write
- count, out, $clog2(DEPTH)+1, number of occupied entries
- empty, out, 1, count == 0

## Operation

- Storage: circular FIFO with DEPTH entries of {addr, data, mask}. It has a head pointer, a tail pointer (both $clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
- Enqueue: when st_valid & st_ready & (st_mask != 0), write the entry at tail, then advance tail.
  - A store with st_mask == 0 is dropped. It is not counted and not written.
- st_ready = (count < DEPTH). It does not look ahead to a same-cycle dequeue, so a full buffer refuses a store even in a cycle where it drains.
- Drain: when !empty & !ld_valid, present the head entry on mem_addr, mem_din and mem_we. Head advances at the edge, so the memory captures the write at that same edge.
  - When empty or ld_valid = 1: mem_we = 0, and mem_addr / mem_din show the head entry (don't-care).
- Hazard: ld_hazard = ld_valid & (any occupied entry has addr == ld_addr).
  - Only entries resident at the start of the cycle are compared. A store enqueued in the same cycle is younger than that load.
- While ld_valid = 1, no drain occurs. The hazard therefore clears only once the load is deasserted, which the core does by stalling and retrying.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Occupancy update: count updates by +1 (enqueue only), −1 (dequeue only) or 0 (both or neither).

## Timing

- Reset at a rising edge with rst = 1:
  - head = tail = count = 0; all entries are marked invalid.
  - Outputs: st_ready = 1, empty = 1, mem_we = 0, ld_hazard = 0.
  - Reset mid-operation discards pending stores, which are never written.
- All outputs are combinational from state and the current-cycle inputs. No output-register latency.
- Minimum store latency: a store accepted at edge k is presented in cycle k+1 and written at edge k+1 if ld_valid = 0 in that cycle.
- Drain throughput: one store per cycle while ld_valid = 0.
- Buffer full with ld_valid held at 1: st_ready = 0 indefinitely. The upstream stage must hold its store.
- ld_hazard paths:
  - combinational from ld_valid and ld_addr, through DEPTH address comparators gated by entry-valid bits;
  - it must meet timing in the same cycle as the load address.

## Test plan

- Single store: reset; at one edge apply st_valid=1, st_addr=0x0010, st_data=0xDEADBEEF, st_mask=4'b1111. In the next cycle, with ld_valid=0, require mem_we=4'b1111, mem_addr=0x0010, mem_din=0xDEADBEEF; the cycle after, require empty=1.
- Fill/ordering: hold ld_valid=1 and enqueue 4 stores (addr 1,2,3,4, data 0xA1..0xA4). Require count=4, st_ready=0, and that a 5th store is not accepted. Release ld_valid; require writes to addr 1,2,3,4 in consecutive cycles, then empty=1.
- Hazard: with addr 0x0022 buffered and ld_valid=1, ld_addr=0x0022, require ld_hazard=1. With ld_addr=0x0023, require ld_hazard=0. Drop ld_valid until drained, then retry addr 0x0022; require ld_hazard=0.
- Zero mask and simultaneous events:
  - st_valid=1 with st_mask=0: count unchanged, no write.
  - With count=2 and ld_valid=0, enqueue and drain in the same cycle: count stays 2 and order is preserved.
- Wrap and reset: push 6 stores through with interleaved drains (pointer wrap) and check in-order writes. Then buffer 3 stores and assert rst for one cycle: count=0, empty=1, mem_we=0 afterwards, and none of the 3 stores is ever written.
